// File: rtl/aibcr3aux_osc_meas_pkg.sv
// aibcr3aux_osc_meas_pkg: shared types and constants for the aux oscillator measurement sequencer
package aibcr3aux_osc_meas_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_EVAL    = 2'd3
  } state_e;
  localparam logic [1:0] DIV16  = 2'd0;
  localparam logic [1:0] DIV32  = 2'd1;
  localparam logic [1:0] DIV64  = 2'd2;
  localparam logic [1:0] DIV64R = 2'd3;
endpackage

// File: rtl/aibcr3aux_osc_meas_sync.sv
// aibcr3aux_osc_meas_sync: multi-stage synchronizer plus rising-edge detector for an async divider output
module aibcr3aux_osc_meas_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q, hist_d;
  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(d);
    hist_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/aibcr3aux_osc_meas_ctrl.sv
// aibcr3aux_osc_meas_ctrl: settles the divider, counts divided-clock edges over a window and checks thresholds
module aibcr3aux_osc_meas_ctrl
  import aibcr3aux_osc_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_start,
  input  logic             meas_abort,
  input  logic             cont_mode,
  input  logic [1:0]       div_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic             osc_div16,
  input  logic             osc_div32,
  input  logic             osc_div64,
  output logic             osc_por,
  output logic             meas_busy,
  output logic             meas_done,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_in_range,
  output logic             meas_ovf
);
  state_e state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [WIN_W-1:0] win_q, win_d, tmr_q, tmr_d;
  logic [CNT_W-1:0] lo_q, lo_d, hi_q, hi_d, cnt_q, cnt_d, res_q, res_d;
  logic ovf_q, ovf_d, rovf_q, rovf_d, rin_q, rin_d, done_q, done_d;
  logic osc_sel, rise, go, meas, cnt_full;
  // mux before the synchronizer so only one async crossing exists
  assign osc_sel = sel_q == DIV16 ? osc_div16 : sel_q == DIV32 ? osc_div32 : osc_div64;
  aibcr3aux_osc_meas_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (osc_sel),
    .rise (rise)
  );
  always_comb begin
    go       = state_q == ST_IDLE && meas_start && !meas_abort;
    meas     = state_q == ST_MEASURE;
    cnt_full = &cnt_q;
    sel_d    = go ? div_sel : sel_q;
    win_d    = go ? win_len : win_q;
    lo_d     = go ? thr_lo : lo_q;
    hi_d     = go ? thr_hi : hi_q;
    state_d  = state_q;
    tmr_d    = tmr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = go ? ST_SETTLE : ST_IDLE;
        tmr_d   = WIN_W'(SETTLE_CYC - 1);
      end
      ST_SETTLE: begin
        state_d = tmr_q != '0 ? ST_SETTLE : win_q == '0 ? ST_EVAL : ST_MEASURE;
        tmr_d   = tmr_q != '0 ? tmr_q - WIN_W'(1) : win_q - WIN_W'(1);
      end
      ST_MEASURE: begin
        state_d = tmr_q != '0 ? ST_MEASURE : ST_EVAL;
        tmr_d   = tmr_q - WIN_W'(1);
      end
      default: begin
        state_d = !cont_mode ? ST_IDLE : win_q == '0 ? ST_EVAL : ST_MEASURE;
        tmr_d   = win_q - WIN_W'(1);
      end
    endcase
    if (meas_abort) state_d = ST_IDLE;
    cnt_d  = meas ? cnt_q + CNT_W'(rise & ~cnt_full) : '0;
    ovf_d  = meas & (ovf_q | (rise & cnt_full));
    done_d = state_d == ST_EVAL;
    res_d  = done_d ? cnt_d : res_q;
    rovf_d = done_d ? ovf_d : rovf_q;
    rin_d  = done_d ? (lo_q <= cnt_d && cnt_d <= hi_q && !ovf_d) : rin_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      win_q   <= '0;
      tmr_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      rovf_q  <= 1'b0;
      rin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      win_q   <= win_d;
      tmr_q   <= tmr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      rovf_q  <= rovf_d;
      rin_q   <= rin_d;
      done_q  <= done_d;
    end
  end
  assign osc_por       = state_q == ST_IDLE;
  assign meas_busy     = state_q != ST_IDLE;
  assign meas_done     = done_q;
  assign meas_count    = res_q;
  assign meas_in_range = rin_q;
  assign meas_ovf      = rovf_q;
endmodule

// File: tb/tb_aibcr3aux_osc_meas_ctrl.sv
// tb_aibcr3aux_osc_meas_ctrl: directed vector and sequence bench for the oscillator measurement sequencer
module tb_aibcr3aux_osc_meas_ctrl;
  localparam int S = 8;
  logic clk = 0, rst_n = 0, meas_start = 0, sat_start = 0, meas_abort = 0, cont_mode = 0;
  logic [1:0] div_sel = 0;
  logic [15:0] win_len = 0, thr_lo = 0, thr_hi = 0;
  logic osc_por, meas_busy, meas_done, meas_in_range, meas_ovf;
  logic [15:0] meas_count;
  logic s_por, s_busy, s_done, s_in, s_ovf;
  logic [3:0] s_count;
  logic [7:0] dcnt = 0;
  logic fcnt = 0;
  int cyc = 0, checks = 0, failures = 0;

  typedef struct {
    logic [1:0] sel;
    int win, lo, hi, cnt;
    bit ir;
  } vec_t;
  vec_t vt[9];

  aibcr3aux_osc_meas_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .meas_start(meas_start), .meas_abort(meas_abort),
    .cont_mode(cont_mode), .div_sel(div_sel), .win_len(win_len), .thr_lo(thr_lo),
    .thr_hi(thr_hi), .osc_div16(dcnt[3]), .osc_div32(dcnt[4]), .osc_div64(dcnt[5]),
    .osc_por(osc_por), .meas_busy(meas_busy), .meas_done(meas_done),
    .meas_count(meas_count), .meas_in_range(meas_in_range), .meas_ovf(meas_ovf)
  );

  aibcr3aux_osc_meas_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .meas_start(sat_start), .meas_abort(meas_abort),
    .cont_mode(cont_mode), .div_sel(div_sel), .win_len(win_len), .thr_lo(thr_lo[3:0]),
    .thr_hi(thr_hi[3:0]), .osc_div16(fcnt), .osc_div32(fcnt), .osc_div64(fcnt),
    .osc_por(s_por), .meas_busy(s_busy), .meas_done(s_done),
    .meas_count(s_count), .meas_in_range(s_in), .meas_ovf(s_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // divider models: held at zero while por is asserted, free-running otherwise
  always @(negedge clk) begin
    dcnt <= osc_por ? 8'd0 : dcnt + 8'd1;
    fcnt <= s_por ? 1'b0 : ~fcnt;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic kick(input bit sat, output int t0);
    @(negedge clk);
    t0 = cyc;
    if (sat) sat_start = 1; else meas_start = 1;
    @(negedge clk);
    sat_start = 0;
    meas_start = 0;
  endtask

  task automatic wait_done(input bit sat, input string nm, output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if ((sat ? s_done : meas_done) === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no done pulse within 400 cycles", nm);
    end
  endtask

  task automatic no_done(input string nm, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (meas_done === 1'b1) seen++;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    int t0, t1, t2, t3;
    vt[0] = '{2'd0, 160, 8, 12, 10, 1'b1};
    vt[1] = '{2'd0, 160, 20, 10, 10, 1'b0};
    vt[2] = '{2'd0, 0, 0, 5, 0, 1'b1};
    vt[3] = '{2'd0, 0, 1, 5, 0, 1'b0};
    vt[4] = '{2'd1, 160, 5, 5, 5, 1'b1};
    vt[5] = '{2'd2, 160, 0, 2, 3, 1'b0};
    vt[6] = '{2'd3, 160, 3, 3, 3, 1'b1};
    vt[7] = '{2'd0, 2, 1, 1, 1, 1'b1};
    vt[8] = '{2'd0, 1, 0, 0, 0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_por", osc_por, 1);
    chk("rst_busy", meas_busy, 0);
    chk("rst_done", meas_done, 0);
    chk("rst_count", meas_count, 0);
    chk("rst_in_range", meas_in_range, 0);
    chk("rst_ovf", meas_ovf, 0);
    rst_n = 1;

    for (int i = 0; i < 9; i++) begin
      div_sel = vt[i].sel;
      win_len = 16'(vt[i].win);
      thr_lo = 16'(vt[i].lo);
      thr_hi = 16'(vt[i].hi);
      kick(0, t0);
      chk($sformatf("vec%0d_busy", i), meas_busy, 1);
      wait_done(0, $sformatf("vec%0d_done", i), t1);
      if (t1 >= 0) begin
        chk($sformatf("vec%0d_latency", i), t1 - t0, S + vt[i].win + 1);
        chk($sformatf("vec%0d_count", i), meas_count, vt[i].cnt);
        chk($sformatf("vec%0d_in_range", i), meas_in_range, int'(vt[i].ir));
        chk($sformatf("vec%0d_ovf", i), meas_ovf, 0);
      end
    end

    // config changed while busy must not affect the running measurement
    div_sel = 2; win_len = 160; thr_lo = 3; thr_hi = 3;
    kick(0, t0);
    div_sel = 0; win_len = 5; thr_lo = 0; thr_hi = 0;
    wait_done(0, "latch_done", t1);
    chk("latch_latency", t1 - t0, S + 161);
    chk("latch_count", meas_count, 3);
    chk("latch_in_range", meas_in_range, 1);

    // start pulse while busy is ignored
    div_sel = 0; win_len = 32; thr_lo = 0; thr_hi = 100;
    kick(0, t0);
    repeat (20) @(negedge clk);
    meas_start = 1;
    @(negedge clk);
    meas_start = 0;
    wait_done(0, "busy_start_done", t1);
    chk("busy_start_latency", t1 - t0, S + 33);
    chk("busy_start_count", meas_count, 2);
    @(negedge clk);
    chk("busy_start_idle_busy", meas_busy, 0);
    chk("busy_start_idle_por", osc_por, 1);
    no_done("busy_start_no_restart", 60);

    // continuous mode: three windows, cont cleared during the third
    cont_mode = 1;
    kick(0, t0);
    wait_done(0, "cont_done1", t1);
    chk("cont_lat1", t1 - t0, S + 33);
    chk("cont_por1", osc_por, 0);
    chk("cont_count1", meas_count, 2);
    @(negedge clk);
    wait_done(0, "cont_done2", t2);
    chk("cont_gap2", t2 - t1, 33);
    chk("cont_por2", osc_por, 0);
    chk("cont_count2", meas_count, 2);
    repeat (5) @(negedge clk);
    chk("cont_busy_mid", meas_busy, 1);
    cont_mode = 0;
    wait_done(0, "cont_done3", t3);
    chk("cont_gap3", t3 - t2, 33);
    chk("cont_count3", meas_count, 2);
    @(negedge clk);
    chk("cont_end_busy", meas_busy, 0);
    chk("cont_end_por", osc_por, 1);

    // abort mid-window keeps the previous results
    win_len = 160;
    kick(0, t0);
    repeat (20) @(negedge clk);
    meas_abort = 1;
    @(negedge clk);
    meas_abort = 0;
    chk("abort_busy", meas_busy, 0);
    chk("abort_por", osc_por, 1);
    chk("abort_count", meas_count, 2);
    chk("abort_in_range", meas_in_range, 1);
    no_done("abort_no_done", 200);

    // reset during settle clears results
    kick(0, t0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("reset_por", osc_por, 1);
    chk("reset_busy", meas_busy, 0);
    chk("reset_count", meas_count, 0);
    chk("reset_in_range", meas_in_range, 0);
    no_done("reset_no_done", 200);

    // 4-bit counter saturates on a period-2 input
    win_len = 100; thr_lo = 0; thr_hi = 15;
    kick(1, t0);
    wait_done(1, "sat_done", t1);
    chk("sat_latency", t1 - t0, S + 101);
    chk("sat_count", s_count, 15);
    chk("sat_ovf", s_ovf, 1);
    chk("sat_in_range", s_in, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
